// File: rtl/seq_pattern_fsm_pkg.sv
// Shared definitions for the serial pattern detector: state encoding and a
// width helper for the fill counter.
package seq_pattern_fsm_pkg;

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SAT  = 2'd2;

    // Bits needed to hold any value in 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             max
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign max = (cnt == CNT_MAX);

endmodule

// File: rtl/seq_pattern_fsm.sv
// Serial pattern detector: shifts in w on enabled edges, compares the newest
// PAT_LEN bits with a programmable pattern and counts matches.
module seq_pattern_fsm
    import seq_pattern_fsm_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               w,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               overlap,
    input  logic               clear,
    output logic               match,
    output logic [CNT_W-1:0]   z,
    output logic               sat
);

    localparam int FW = clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]    FILL_FULL    = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_NEAR_MAX = {{(CNT_W-1){1'b1}}, 1'b0};

    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] hist_next;
    logic [FW-1:0]      fill;
    logic [FW-1:0]      fill_next;
    logic [FW-1:0]      fill_after;
    logic [1:0]         state;
    logic [1:0]         state_next;
    logic               detect;

    // fill_after is what the fill count becomes once a non-overlap match
    // forces a fresh PAT_LEN-bit refill; the state follows that value.
    always_comb begin
        hist_next  = hist;
        fill_next  = fill;
        if (en) begin
            hist_next = {hist[PAT_LEN-2:0], w};
            fill_next = (fill == FILL_FULL) ? fill : fill + 1'b1;
        end
        detect     = en && (fill_next == FILL_FULL) && (hist_next == pattern);
        fill_after = (detect && !overlap) ? '0 : fill_next;

        if (clear) begin
            state_next = (fill_after == FILL_FULL) ? ST_RUN : ST_FILL;
        end else if ((state == ST_SAT) || (detect && (z == CNT_NEAR_MAX))) begin
            state_next = ST_SAT;
        end else if (fill_after == FILL_FULL) begin
            state_next = ST_RUN;
        end else begin
            state_next = ST_FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist  <= '0;
            fill  <= '0;
            state <= ST_FILL;
            match <= 1'b0;
        end else begin
            hist  <= hist_next;
            fill  <= fill_after;
            state <= state_next;
            match <= detect && !clear;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (detect),
        .cnt   (z),
        .max   (sat)
    );

endmodule

// File: tb/tb_seq_pattern_fsm.sv
// Self-checking bench for seq_pattern_fsm: directed scenarios followed by
// random traffic, all checked against a bit-queue reference model.
module tb_seq_pattern_fsm;

    localparam int PL   = 4;
    localparam int CW   = 3;
    localparam int ZMAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          en;
    logic          w;
    logic [PL-1:0] pattern;
    logic          overlap;
    logic          clear;
    logic          match;
    logic [CW-1:0] z;
    logic          sat;

    int errors;
    int checks;

    // Reference model: recent bits, bits seen since last reset/refill, count.
    int q[$];
    int fresh;
    int mz;
    int mmatch;

    seq_pattern_fsm #(
        .PAT_LEN (PL),
        .CNT_W   (CW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .w       (w),
        .pattern (pattern),
        .overlap (overlap),
        .clear   (clear),
        .match   (match),
        .z       (z),
        .sat     (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int det;
        if (reset) begin
            q.delete();
            fresh  = 0;
            mz     = 0;
            mmatch = 0;
        end else begin
            det = 0;
            if (en) begin
                q.push_back(int'(w));
                if (q.size() > PL) void'(q.pop_front());
                if (fresh < PL) fresh++;
                if (fresh == PL) begin
                    det = 1;
                    for (int i = 0; i < PL; i++)
                        if (q[i] != int'(pattern[PL-1-i])) det = 0;
                end
                if (det == 1 && !overlap) fresh = 0;
            end
            if (clear) begin
                mz     = 0;
                mmatch = 0;
            end else begin
                mmatch = det;
                if (det == 1 && mz < ZMAX) mz++;
            end
        end
    endtask

    task automatic check_output();
        check_value("match", 32'(match), 32'(mmatch));
        check_value("z", 32'(z), 32'(mz));
        check_value("sat", 32'(sat), (mz == ZMAX) ? 32'd1 : 32'd0);
    endtask

    task automatic apply_stimulus(input logic r, input logic e, input logic wv, input logic c);
        reset = r;
        en    = e;
        w     = wv;
        clear = c;
        @(posedge clk);
        model_step();
        #1;
        check_output();
    endtask

    // Sends n bits, oldest first (bits[n-1] goes out first).
    task automatic send_stream(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) apply_stimulus(1'b0, 1'b1, bits[i], 1'b0);
    endtask

    task automatic do_reset();
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        fresh   = 0;
        mz      = 0;
        mmatch  = 0;
        reset   = 1'b1;
        en      = 1'b0;
        w       = 1'b0;
        clear   = 1'b0;
        pattern = 4'b1011;
        overlap = 1'b1;

        do_reset();
        do_reset();
        check_value("reset_z", 32'(z), 32'd0);

        send_stream(32'b1011011, 7);
        check_value("ovl_z", 32'(z), 32'd2);
        check_value("ovl_sat", 32'(sat), 32'd0);

        overlap = 1'b0;
        do_reset();
        send_stream(32'b1011011, 7);
        check_value("novl_z1", 32'(z), 32'd1);
        do_reset();
        send_stream(32'b10111011, 8);
        check_value("novl_z2", 32'(z), 32'd2);

        pattern = 4'b0000;
        overlap = 1'b1;
        do_reset();
        send_stream(32'b0, 12);
        check_value("sat_z", 32'(z), 32'(ZMAX));
        check_value("sat_flag", 32'(sat), 32'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
        check_value("clear_z", 32'(z), 32'd0);
        send_stream(32'b0, 1);
        check_value("after_clear_z", 32'(z), 32'd1);

        pattern = 4'b1011;
        do_reset();
        send_stream(32'b101, 3);
        do_reset();
        send_stream(32'b1, 1);
        check_value("midreset_nomatch", 32'(match), 32'd0);
        send_stream(32'b011, 3);
        check_value("midreset_match", 32'(match), 32'd1);
        check_value("midreset_z", 32'(z), 32'd1);

        do_reset();
        send_stream(32'b10, 2);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        send_stream(32'b11, 2);
        check_value("en_gap_match", 32'(match), 32'd1);

        do_reset();
        send_stream(32'b1011011, 7);
        send_stream(32'b01, 2);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1);
        check_value("clr_det_z", 32'(z), 32'd0);
        check_value("clr_det_match", 32'(match), 32'd0);

        pattern = 4'b0000;
        do_reset();
        send_stream(32'b0, 8);
        check_value("pre_reset_z", 32'(z), 32'd5);
        do_reset();
        check_value("post_reset_z", 32'(z), 32'd0);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) pattern = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) overlap = ~overlap;
            apply_stimulus($urandom_range(0, 59) == 0,
                           $urandom_range(0, 9) != 0,
                           1'($urandom_range(0, 1)),
                           $urandom_range(0, 24) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_pattern_fsm.md
Name: seq_pattern_fsm

Overview:
- Parametrised serial pattern detector FSM; successor to the fixed single-input FSM block.
- Samples 1-bit serial stream `w` each enabled clock and compares the last PAT_LEN bits against a runtime-programmable pattern.
- Supports overlapping and non-overlapping detection modes.
- Outputs a one-cycle match pulse and a saturating match count `z`.
- Sits between a serial input source and downstream status/count logic.

Parameters:
- PAT_LEN, 4, pattern length in bits (>=2).
- CNT_W, 4, width of match counter z.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  sample enable; w ignored when low.
- w  input  1  serial data bit.
- pattern  input  PAT_LEN  target pattern; pattern[PAT_LEN-1] is the first-received bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- clear  input  1  synchronous clear of z, sat and match.
- match  output  1  registered one-cycle pulse per detection.
- z  output  CNT_W  registered saturating match count.
- sat  output  1  high when z has reached 2^CNT_W-1.

Behaviour:
- One clock; reset is synchronous and active-high. On reset edge:
  - z=0, match=0, sat=0.
  - History register = 0, fill count = 0, state = FILL.
- History update: at each rising edge with en=1, hist_next = {hist[PAT_LEN-2:0], w} and fill_next = min(fill+1, PAT_LEN).
- States:
  - FILL: fill_next < PAT_LEN, or the post-match refill in non-overlap mode. No compare.
  - RUN: fill == PAT_LEN. Compare hist_next with the `pattern` value present at that edge.
  - SAT: RUN behaviour with z frozen at max.
  - Transitions: FILL->RUN when fill_next reaches PAT_LEN. RUN->SAT when z increments to max. SAT->RUN on clear. Any state->FILL on reset.
- Detect condition: hist_next == pattern and fill_next == PAT_LEN.
- Latency: match goes high at the same edge that samples the completing bit (visible the following cycle). It lasts exactly one cycle unless the next enabled edge also detects.
- On detect:
  - z increments by 1 unless already 2^CNT_W-1; then z holds, match still pulses.
  - sat asserts on the edge where z becomes max.
- Overlap=1: history is retained after a match; a shared suffix/prefix can produce back-to-back matches.
- Overlap=0: after a match, fill is cleared to 0, so the next match needs PAT_LEN fresh bits. The state returns to FILL (or remains SAT if saturated; the refill is still enforced via fill).
- en=0: history, fill, z and state hold; match=0 that cycle.
- clear=1 (not reset): z=0, sat=0, match=0; SAT->RUN; history and fill unaffected.
- Simultaneous events:
  - clear and detect on the same edge: clear wins, z=0, match=0.
  - reset overrides everything.
- pattern or overlap changed mid-stream: takes effect at the next edge; no resync of history.
- Reset mid-fill: partial history discarded; a full PAT_LEN bits are needed afterwards.

Decomposition:
- Shared package (fsm_pkg):
  - State encoding localparams ST_FILL=2'd0, ST_RUN=2'd1, ST_SAT=2'd2.
  - Fill-count width function clog2(PAT_LEN+1).
- One natural sub-module: sat_counter.
  - Parameter CNT_W.
  - Ports: clk, reset, clr, inc, cnt, max.
  - Behaviour: saturating increment; clr has priority over inc.

Test Plan:
- PAT_LEN=4, pattern=4'b1011, overlap=1, en=1, stream 1,0,1,1,0,1,1 -> match pulses after bit 4 and bit 7; z=2, sat=0.
- Same stream, overlap=0 -> single match after bit 4; z=1. Stream 1,0,1,1,1,0,1,1 -> matches after bits 4 and 8; z=2.
- CNT_W=2, pattern=4'b0000, overlap=1, w=0 for 9 cycles:
  - 6 match pulses (bits 4–9).
  - z counts 1,2,3 and holds at 3; sat=1 from the third match.
  - Then clear=1 -> z=0, sat=0; next w=0 bit -> match, z=1.
- Stream 1,0,1 then reset=1 one cycle, then 1 -> no match; then 0,1,1 -> match after the 4th post-reset bit; z=1.
- Stream 1,0 then en=0 for 3 cycles (w toggling) then en=1 with 1,1 -> match on the last bit; no match during en=0.
- Detect and clear on the same edge (z=2 before) -> z=0, match=0 next cycle; reset with z=5 -> z=0, match=0, sat=0.
